// File: rtl/mem_stage_if.sv
// mem_stage_if: bundle between the EX/MEM pipeline register, the MEM stage and its consumers.
//   i_* signals: pipeline controls (enable, flush), the EX-stage result bundle and the
//                debug read request. They are driven by the master and read by the stage.
//   o_* signals: branch redirect, EX forwarding data, the registered MEM/WB bundle,
//                status flags and debug read data. They are driven by the stage (slave).
interface mem_stage_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_PC   = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_ADDR = 8
);
    logic               i_enable;
    logic               i_flush;
    logic               i_MEM_signed;
    logic               i_MEM_reg_write;
    logic               i_MEM_mem_to_reg;
    logic               i_MEM_mem_read;
    logic               i_MEM_mem_write;
    logic               i_MEM_branch;
    logic               i_MEM_jump;
    logic               i_MEM_zero;
    logic [NB_PC-1:0]   i_MEM_branch_addr;
    logic [NB_DATA-1:0] i_MEM_alu_result;
    logic [NB_DATA-1:0] i_MEM_data_b;
    logic [NB_REG-1:0]  i_MEM_selected_reg;
    logic               i_MEM_byte_en;
    logic               i_MEM_halfword_en;
    logic               i_MEM_word_en;
    logic               i_MEM_r31_ctrl;
    logic [NB_PC-1:0]   i_MEM_pc;
    logic               i_MEM_hlt;
    logic               i_debug_rd_en;
    logic [NB_ADDR-1:0] i_debug_addr;

    logic               o_MEM_pc_src;
    logic [NB_PC-1:0]   o_MEM_branch_addr;
    logic [NB_DATA-1:0] o_MEM_fwd_data;
    logic               o_WB_reg_write;
    logic               o_WB_mem_to_reg;
    logic               o_WB_r31_ctrl;
    logic               o_WB_hlt;
    logic [NB_DATA-1:0] o_WB_alu_result;
    logic [NB_DATA-1:0] o_WB_mem_data;
    logic [NB_REG-1:0]  o_WB_selected_reg;
    logic [NB_PC-1:0]   o_WB_pc;
    logic               o_misaligned;
    logic               o_halted;
    logic [NB_DATA-1:0] o_debug_data;
    logic               o_debug_valid;

    modport master (
        output i_enable, i_flush, i_MEM_signed, i_MEM_reg_write, i_MEM_mem_to_reg,
               i_MEM_mem_read, i_MEM_mem_write, i_MEM_branch, i_MEM_jump, i_MEM_zero,
               i_MEM_branch_addr, i_MEM_alu_result, i_MEM_data_b, i_MEM_selected_reg,
               i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en, i_MEM_r31_ctrl, i_MEM_pc,
               i_MEM_hlt, i_debug_rd_en, i_debug_addr,
        input  o_MEM_pc_src, o_MEM_branch_addr, o_MEM_fwd_data, o_WB_reg_write,
               o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_hlt, o_WB_alu_result, o_WB_mem_data,
               o_WB_selected_reg, o_WB_pc, o_misaligned, o_halted, o_debug_data,
               o_debug_valid
    );

    modport slave (
        input  i_enable, i_flush, i_MEM_signed, i_MEM_reg_write, i_MEM_mem_to_reg,
               i_MEM_mem_read, i_MEM_mem_write, i_MEM_branch, i_MEM_jump, i_MEM_zero,
               i_MEM_branch_addr, i_MEM_alu_result, i_MEM_data_b, i_MEM_selected_reg,
               i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en, i_MEM_r31_ctrl, i_MEM_pc,
               i_MEM_hlt, i_debug_rd_en, i_debug_addr,
        output o_MEM_pc_src, o_MEM_branch_addr, o_MEM_fwd_data, o_WB_reg_write,
               o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_hlt, o_WB_alu_result, o_WB_mem_data,
               o_WB_selected_reg, o_WB_pc, o_misaligned, o_halted, o_debug_data,
               o_debug_valid
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the MIPS core.
//   i_clock  : clock, all state updates on the rising edge
//   i_reset  : synchronous active-low reset (memory contents are kept)
//   bus      : mem_stage_if slave -- EX result bundle in; redirect, forwarding,
//              MEM/WB bundle, misaligned/halt status and debug read port out.
// Byte/halfword/word stores and sign/zero-extended loads on an internal synchronous
// 2**NB_ADDR-word data memory. Lane logic assumes NB_DATA = 32.
module mem_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_PC   = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic      i_clock,
    input  logic      i_reset,
    mem_stage_if.slave bus
);
    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         off;
    logic               sz_word, sz_half, sz_byte;
    logic               misaligned;
    logic               advance;
    logic               store_en;
    logic [3:0]         lane_we;
    logic [NB_DATA-1:0] wdata;

    logic               halted_q;
    logic               mis_pulse_q;
    logic [NB_DATA-1:0] rd_data_q;
    logic [1:0]         off_q;
    logic               half_q, byte_q, signed_q, ld_mis_q;
    logic               dbg_valid_q;
    logic [NB_DATA-1:0] dbg_data_q;

    logic [NB_DATA-1:0] ld_ext;
    logic [NB_DATA-1:0] ld_shifted;
    logic [15:0]        ld_half;
    logic [7:0]         ld_byte;

    // Address bits above the memory depth are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.i_MEM_alu_result[NB_DATA-1:NB_ADDR+2];

    assign word_idx = bus.i_MEM_alu_result[NB_ADDR+1:2];
    assign off      = bus.i_MEM_alu_result[1:0];

    always_comb begin
        sz_word    = bus.i_MEM_word_en;
        sz_half    = !bus.i_MEM_word_en && bus.i_MEM_halfword_en;
        sz_byte    = !bus.i_MEM_word_en && !bus.i_MEM_halfword_en && bus.i_MEM_byte_en;
        misaligned = (sz_half && off[0]) || (sz_word && (off != 2'b00));
        advance    = bus.i_enable && !bus.i_flush;
        lane_we    = 4'b0000;
        wdata      = bus.i_MEM_data_b;
        if (sz_word) begin
            lane_we = 4'b1111;
        end else if (sz_half) begin
            lane_we = off[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{bus.i_MEM_data_b[15:0]}};
        end else if (sz_byte) begin
            lane_we = 4'b0001 << off;
            wdata   = {4{bus.i_MEM_data_b[7:0]}};
        end
        store_en = advance && bus.i_MEM_mem_write && !halted_q && !misaligned;
    end

    always_ff @(posedge i_clock) begin
        for (int i = 0; i < 4; i++) begin
            if (store_en && lane_we[i]) begin
                mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            halted_q              <= 1'b0;
            mis_pulse_q           <= 1'b0;
            rd_data_q             <= '0;
            off_q                 <= 2'b00;
            half_q                <= 1'b0;
            byte_q                <= 1'b0;
            signed_q              <= 1'b0;
            ld_mis_q              <= 1'b0;
            dbg_valid_q           <= 1'b0;
            dbg_data_q            <= '0;
            bus.o_WB_reg_write    <= 1'b0;
            bus.o_WB_mem_to_reg   <= 1'b0;
            bus.o_WB_r31_ctrl     <= 1'b0;
            bus.o_WB_hlt          <= 1'b0;
            bus.o_WB_alu_result   <= '0;
            bus.o_WB_selected_reg <= '0;
            bus.o_WB_pc           <= '0;
        end else begin
            mis_pulse_q <= advance && (bus.i_MEM_mem_read || bus.i_MEM_mem_write) && misaligned;
            dbg_valid_q <= bus.i_debug_rd_en;
            if (bus.i_debug_rd_en) begin
                dbg_data_q <= mem[bus.i_debug_addr];
            end
            if (bus.i_enable) begin
                // Read-before-write is fine: a store at N is visible to a load sampled at N+1.
                rd_data_q             <= mem[word_idx];
                off_q                 <= off;
                half_q                <= sz_half;
                byte_q                <= sz_byte;
                signed_q              <= bus.i_MEM_signed;
                ld_mis_q              <= misaligned;
                bus.o_WB_reg_write    <= bus.i_MEM_reg_write && !bus.i_flush;
                bus.o_WB_mem_to_reg   <= bus.i_MEM_mem_to_reg && !bus.i_flush;
                bus.o_WB_r31_ctrl     <= bus.i_MEM_r31_ctrl && !bus.i_flush;
                bus.o_WB_hlt          <= bus.i_MEM_hlt && !bus.i_flush;
                bus.o_WB_alu_result   <= bus.i_MEM_alu_result;
                bus.o_WB_selected_reg <= bus.i_MEM_selected_reg;
                bus.o_WB_pc           <= bus.i_MEM_pc;
                if (!bus.i_flush && bus.i_MEM_hlt) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

    // Load extraction; no size bits selected returns the full word.
    always_comb begin
        ld_shifted = rd_data_q >> {off_q, 3'b000};
        ld_byte    = ld_shifted[7:0];
        ld_half    = off_q[1] ? rd_data_q[31:16] : rd_data_q[15:0];
        ld_ext     = rd_data_q;
        if (ld_mis_q) begin
            ld_ext = '0;
        end else if (half_q) begin
            ld_ext = {{(NB_DATA-16){signed_q && ld_half[15]}}, ld_half};
        end else if (byte_q) begin
            ld_ext = {{(NB_DATA-8){signed_q && ld_byte[7]}}, ld_byte};
        end
    end

    assign bus.o_WB_mem_data     = ld_ext;
    assign bus.o_MEM_pc_src      = (bus.i_MEM_branch && bus.i_MEM_zero) || bus.i_MEM_jump;
    assign bus.o_MEM_branch_addr = bus.i_MEM_branch_addr;
    assign bus.o_MEM_fwd_data    = bus.i_MEM_alu_result;
    assign bus.o_misaligned      = mis_pulse_q;
    assign bus.o_halted          = halted_q;
    assign bus.o_debug_data      = dbg_data_q;
    assign bus.o_debug_valid     = dbg_valid_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Expected load data is pushed to a
// scoreboard queue when a load is driven and popped when the MEM/WB output appears.
module tb_mem_stage;
    logic i_clock = 1'b0;
    logic i_reset = 1'b0;

    mem_stage_if bus ();

    mem_stage dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_enable           = 1'b1;
        bus.i_flush            = 1'b0;
        bus.i_MEM_signed       = 1'b0;
        bus.i_MEM_reg_write    = 1'b0;
        bus.i_MEM_mem_to_reg   = 1'b0;
        bus.i_MEM_mem_read     = 1'b0;
        bus.i_MEM_mem_write    = 1'b0;
        bus.i_MEM_branch       = 1'b0;
        bus.i_MEM_jump         = 1'b0;
        bus.i_MEM_zero         = 1'b0;
        bus.i_MEM_branch_addr  = '0;
        bus.i_MEM_alu_result   = '0;
        bus.i_MEM_data_b       = '0;
        bus.i_MEM_selected_reg = '0;
        bus.i_MEM_byte_en      = 1'b0;
        bus.i_MEM_halfword_en  = 1'b0;
        bus.i_MEM_word_en      = 1'b0;
        bus.i_MEM_r31_ctrl     = 1'b0;
        bus.i_MEM_pc           = '0;
        bus.i_MEM_hlt          = 1'b0;
        bus.i_debug_rd_en      = 1'b0;
        bus.i_debug_addr       = '0;
    endtask

    // sz: 0 none, 1 byte, 2 halfword, 3 word.
    task automatic op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_mis, input logic [31:0] exp_data);
        logic [31:0] e;
        bus.i_enable           = 1'b1;
        bus.i_flush            = 1'b0;
        bus.i_MEM_mem_read     = rd;
        bus.i_MEM_mem_write    = wr;
        bus.i_MEM_byte_en      = (sz == 2'd1);
        bus.i_MEM_halfword_en  = (sz == 2'd2);
        bus.i_MEM_word_en      = (sz == 2'd3);
        bus.i_MEM_signed       = sgn;
        bus.i_MEM_alu_result   = addr;
        bus.i_MEM_data_b       = data;
        bus.i_MEM_reg_write    = rd;
        bus.i_MEM_mem_to_reg   = rd;
        bus.i_MEM_selected_reg = addr[4:0];
        bus.i_MEM_pc           = addr + 32'h1000;
        if (rd) exp_q.push_back(exp_data);
        step();
        check({tag, "_mis"}, {31'd0, bus.o_misaligned}, {31'd0, exp_mis});
        if (rd) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.o_WB_mem_data, e);
        end
        bus.i_MEM_mem_read  = 1'b0;
        bus.i_MEM_mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        bus.i_MEM_reg_write  = 1'b1;
        bus.i_MEM_hlt        = 1'b1;
        bus.i_MEM_alu_result = 32'h1234;
        bus.i_debug_rd_en    = 1'b1;
        i_reset = 1'b0;
        step();
        step();
        check("rst_reg_write", {31'd0, bus.o_WB_reg_write}, 32'd0);
        check("rst_mem_to_reg", {31'd0, bus.o_WB_mem_to_reg}, 32'd0);
        check("rst_r31", {31'd0, bus.o_WB_r31_ctrl}, 32'd0);
        check("rst_hlt", {31'd0, bus.o_WB_hlt}, 32'd0);
        check("rst_alu", bus.o_WB_alu_result, 32'd0);
        check("rst_sel", {27'd0, bus.o_WB_selected_reg}, 32'd0);
        check("rst_pc", bus.o_WB_pc, 32'd0);
        check("rst_memdata", bus.o_WB_mem_data, 32'd0);
        check("rst_halted", {31'd0, bus.o_halted}, 32'd0);
        check("rst_dbg_valid", {31'd0, bus.o_debug_valid}, 32'd0);
        check("rst_mis", {31'd0, bus.o_misaligned}, 32'd0);
        clear_inputs();
        i_reset = 1'b1;
        step();

        // Byte loads, signed and unsigned
        op("sw_dead", 0, 1, 3, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        op("lb_13", 1, 0, 1, 1, 32'h13, 32'h0, 0, 32'hFFFFFFDE);
        op("lbu_10", 1, 0, 1, 0, 32'h10, 32'h0, 0, 32'h000000EF);
        op("lh_12", 1, 0, 2, 1, 32'h12, 32'h0, 0, 32'hFFFFDEAD);
        op("lhu_10", 1, 0, 2, 0, 32'h10, 32'h0, 0, 32'h0000BEEF);
        check("wb_reg_write", {31'd0, bus.o_WB_reg_write}, 32'd1);
        check("wb_pc", bus.o_WB_pc, 32'h1010);

        // Halfword store into upper lanes, store then immediate load
        op("sh_12", 0, 1, 2, 0, 32'h12, 32'hFFFF1234, 0, 32'h0);
        op("lw_10", 1, 0, 3, 0, 32'h10, 32'h0, 0, 32'h1234BEEF);
        op("sb_15", 0, 1, 1, 0, 32'h15, 32'h000000A5, 0, 32'h0);
        op("lw_14", 1, 0, 3, 0, 32'h14, 32'h0, 0, {16'hxxxx, 8'hA5, 8'hxx} & 32'h0000FF00);

        // Misaligned accesses
        op("lw_11", 1, 0, 3, 0, 32'h11, 32'h0, 1, 32'h0);
        op("lbu_after_mis", 1, 0, 1, 0, 32'h10, 32'h0, 0, 32'h000000EF);
        op("sw_12_mis", 0, 1, 3, 0, 32'h12, 32'hFFFFFFFF, 1, 32'h0);
        op("sh_11_mis", 0, 1, 2, 0, 32'h11, 32'hFFFFFFFF, 1, 32'h0);
        op("lw_after_mis", 1, 0, 3, 0, 32'h10, 32'h0, 0, 32'h1234BEEF);

        // Stall: store inhibited and WB bundle held
        bus.i_enable          = 1'b0;
        bus.i_MEM_mem_write   = 1'b1;
        bus.i_MEM_word_en     = 1'b1;
        bus.i_MEM_alu_result  = 32'h411;
        bus.i_MEM_data_b      = 32'hAAAAAAAA;
        bus.i_MEM_reg_write   = 1'b0;
        step();
        check("stall_alu", bus.o_WB_alu_result, 32'h10);
        check("stall_reg_write", {31'd0, bus.o_WB_reg_write}, 32'd1);
        check("stall_memdata", bus.o_WB_mem_data, 32'h1234BEEF);
        check("stall_mis", {31'd0, bus.o_misaligned}, 32'd0);

        // Flush: WB flags cleared, no store, no halt
        bus.i_enable          = 1'b1;
        bus.i_flush           = 1'b1;
        bus.i_MEM_alu_result  = 32'h410;
        bus.i_MEM_reg_write   = 1'b1;
        bus.i_MEM_mem_to_reg  = 1'b1;
        bus.i_MEM_r31_ctrl    = 1'b1;
        bus.i_MEM_hlt         = 1'b1;
        step();
        check("flush_reg_write", {31'd0, bus.o_WB_reg_write}, 32'd0);
        check("flush_mem_to_reg", {31'd0, bus.o_WB_mem_to_reg}, 32'd0);
        check("flush_r31", {31'd0, bus.o_WB_r31_ctrl}, 32'd0);
        check("flush_hlt", {31'd0, bus.o_WB_hlt}, 32'd0);
        check("flush_halted", {31'd0, bus.o_halted}, 32'd0);
        clear_inputs();
        op("lw_after_flush", 1, 0, 3, 0, 32'h410, 32'h0, 0, 32'h1234BEEF);
        op("lw_nosize", 1, 0, 0, 1, 32'h10, 32'h0, 0, 32'h1234BEEF);

        // Redirect and forwarding (combinational)
        bus.i_MEM_branch = 1'b1; bus.i_MEM_zero = 1'b1; bus.i_MEM_alu_result = 32'h5A5A0001;
        bus.i_MEM_branch_addr = 32'h00400080;
        #1;
        check("pc_src_taken", {31'd0, bus.o_MEM_pc_src}, 32'd1);
        check("fwd_data", bus.o_MEM_fwd_data, 32'h5A5A0001);
        check("branch_addr", bus.o_MEM_branch_addr, 32'h00400080);
        bus.i_MEM_zero = 1'b0;
        #1;
        check("pc_src_not_taken", {31'd0, bus.o_MEM_pc_src}, 32'd0);
        bus.i_MEM_branch = 1'b0; bus.i_MEM_jump = 1'b1;
        #1;
        check("pc_src_jump", {31'd0, bus.o_MEM_pc_src}, 32'd1);
        clear_inputs();

        // Halt, then stores inhibited
        op("sw_14", 0, 1, 3, 0, 32'h14, 32'hCAFEF00D, 0, 32'h0);
        bus.i_MEM_hlt      = 1'b1;
        bus.i_MEM_r31_ctrl = 1'b1;
        op("hlt", 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        check("halted", {31'd0, bus.o_halted}, 32'd1);
        check("wb_hlt", {31'd0, bus.o_WB_hlt}, 32'd1);
        check("wb_r31", {31'd0, bus.o_WB_r31_ctrl}, 32'd1);
        bus.i_MEM_hlt      = 1'b0;
        bus.i_MEM_r31_ctrl = 1'b0;
        op("sw_halted", 0, 1, 3, 0, 32'h10, 32'h55555555, 0, 32'h0);
        op("lw_halted", 1, 0, 3, 0, 32'h10, 32'h0, 0, 32'h1234BEEF);
        check("halted_sticky", {31'd0, bus.o_halted}, 32'd1);

        // Debug port, back-to-back reads
        bus.i_debug_rd_en = 1'b1;
        bus.i_debug_addr  = 8'd4;
        step();
        check("dbg_valid0", {31'd0, bus.o_debug_valid}, 32'd1);
        check("dbg_data4", bus.o_debug_data, 32'h1234BEEF);
        bus.i_debug_addr = 8'd5;
        step();
        check("dbg_valid1", {31'd0, bus.o_debug_valid}, 32'd1);
        check("dbg_data5", bus.o_debug_data, 32'hCAFEF00D);
        bus.i_debug_rd_en = 1'b0;
        step();
        check("dbg_valid_low", {31'd0, bus.o_debug_valid}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
